bram_read_arbiter: RTL and testbench
====================================

Name: bram_read_arbiter

Overview:
- Shares the single read-only parameter BRAM between up to N_REQ loader clients, such as the weight and bias loaders of each layer.
- Each client posts a burst request (base address, length). The arbiter grants one client at a time in round-robin order and issues sequential BRAM reads for that burst.
- It absorbs the fixed BRAM read latency and returns an indexed, valid-qualified data stream, then pulses a per-client done.
- It sits between the loader FSMs and the BRAM instance, and drives the BRAM en/ren/addr pins.

Parameters:
N_REQ, 4, number of requesting clients
W, 8, BRAM data width
ADDR_WIDTH, 15, BRAM address width
LEN_WIDTH, 8, burst length field width (max burst 2^LEN_WIDTH-1 words)
READ_LATENCY, 2, cycles from address presented (ren=1) to valid bram_dout

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
req  input  N_REQ  per-client burst request level; held until that client's done
base_addr  input  N_REQ*ADDR_WIDTH  client i start address at [i*ADDR_WIDTH +: ADDR_WIDTH]
burst_len  input  N_REQ*LEN_WIDTH  client i word count at [i*LEN_WIDTH +: LEN_WIDTH]
grant  output  N_REQ  one-hot owner of current burst, all-zero when idle
data_valid  output  1  data_out/data_idx valid this cycle
data_out  output  W  returned BRAM word
data_idx  output  LEN_WIDTH  word index within burst, 0..len-1
done  output  N_REQ  one-cycle pulse to the owning client at burst end
busy  output  1  high in any state other than IDLE
bram_en  output  1  BRAM enable
bram_ren  output  1  BRAM read enable
bram_addr  output  ADDR_WIDTH  BRAM address
bram_dout  input  W  BRAM read data

Behaviour:
- Reset: state=IDLE; grant, done, data_valid, busy, bram_en and bram_ren = 0; bram_addr, data_out and data_idx = 0; rr_ptr = 0. Any in-flight burst is abandoned and its late BRAM data is discarded; no done is pulsed.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: at an edge where req != 0, the winner is latched and the next state is ISSUE, or DONE when the latched len = 0. The winner is the first set req bit scanning upward from rr_ptr, with wrap.
- Latched per burst: owner index, base, len. Later changes on base_addr, burst_len or the owner's req are ignored until DONE.
- ISSUE: grant, bram_en and bram_ren are high. bram_addr = base + k on the k-th ISSUE cycle, k = 0..len-1, so there are exactly len cycles. Address arithmetic is modulo 2^ADDR_WIDTH and wraps silently.
- DRAIN: bram_ren = 0 and bram_en = 1. Lasts READ_LATENCY+1 cycles.
- Data path:
  - The word addressed in cycle t is valid on bram_dout in cycle t+READ_LATENCY.
  - It is registered and presented with data_valid=1 in cycle t+READ_LATENCY+1.
  - data_idx = k for that word. Words are contiguous, with no gaps inside a burst.
- DONE (1 cycle):
  - done[owner] = 1, all other done bits = 0; grant = 0, bram_en = 0.
  - rr_ptr = (owner+1) mod N_REQ.
  - Next state is IDLE.
- Minimum gap: one IDLE cycle between bursts. A request that is still held is re-arbitrated there.
- Fairness: with all clients requesting continuously, grants rotate 0,1,2,3,0,...
- Simultaneous events:
  - A new req arriving during a burst waits.
  - A req that drops mid-burst does not abort the burst.
  - The client must drop req in the cycle after done, or it is re-arbitrated.
- Latency, len = L ≥ 1: req sampled at edge E0 → ISSUE in cycles 1..L → data_valid in cycles 4..L+3 (READ_LATENCY=2) → DONE in cycle L+4.
- len = 0: no BRAM access and no data_valid; done is pulsed in cycle 1.
- data_valid is never asserted outside a burst. data_out holds its last value when data_valid = 0.

Test Plan:
- Single burst: rst for 2 cycles, then req=4'b0010, base[1]=16400, len[1]=8 → grant=4'b0010 from cycle 1; bram_addr 16400..16407 in cycles 1..8; data_valid in cycles 4..11 with data_idx 0..7 matching the BRAM model contents; done[1] pulses in cycle 12; busy high in cycles 1..12.
- Round robin: req=4'b1111 held, every len=2 → grant order 0,1,2,3,0. Each burst is followed by exactly one IDLE cycle, and there are 4 done pulses in index order.
- Zero length: req[2] with len=0 → done[2] in cycle 1; bram_ren never high; data_valid never high.
- Address wrap: base=32766, len=4 → bram_addr sequence 32766, 32767, 0, 1, and data_idx 0..3 carries the matching words.
- Reset mid-burst: assert rst in cycle 5 of a len=8 burst → next cycle all outputs are 0 and no done or data_valid appears afterwards. req[0] then gets a fresh burst, with rr_ptr back at 0.
- Request churn: req[3] rises during client 0's burst and client 0 drops req mid-burst → client 0's burst completes all len words with done[0]; client 3 is granted after the IDLE cycle.

Source files
------------

// File: rtl/bram_read_arbiter_if.sv
// bram_read_arbiter_if: client burst requests, returned data stream and BRAM pins of the read arbiter.
interface bram_read_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 15,
  parameter int LEN_WIDTH  = 8
);
  logic [N_REQ-1:0]            req;
  logic [N_REQ*ADDR_WIDTH-1:0] base_addr;
  logic [N_REQ*LEN_WIDTH-1:0]  burst_len;
  logic [N_REQ-1:0]            grant;
  logic                        data_valid;
  logic [W-1:0]                data_out;
  logic [LEN_WIDTH-1:0]        data_idx;
  logic [N_REQ-1:0]            done;
  logic                        busy;
  logic                        bram_en;
  logic                        bram_ren;
  logic [ADDR_WIDTH-1:0]       bram_addr;
  logic [W-1:0]                bram_dout;
  modport master (
    input  req, base_addr, burst_len, bram_dout,
    output grant, data_valid, data_out, data_idx, done, busy, bram_en, bram_ren, bram_addr
  );
  modport slave (
    output req, base_addr, burst_len, bram_dout,
    input  grant, data_valid, data_out, data_idx, done, busy, bram_en, bram_ren, bram_addr
  );
endinterface

// File: rtl/bram_read_arbiter.sv
// bram_read_arbiter: round-robin sharing of one read-only BRAM among burst-reading clients.
module bram_read_arbiter #(
  parameter int N_REQ        = 4,
  parameter int W            = 8,
  parameter int ADDR_WIDTH   = 15,
  parameter int LEN_WIDTH    = 8,
  parameter int READ_LATENCY = 2
) (
  input logic clk,
  input logic rst,
  bram_read_arbiter_if.master bus
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t                  state, state_nx;
  logic [IW-1:0]           rr_ptr, owner, win;
  logic [ADDR_WIDTH-1:0]   base;
  logic [LEN_WIDTH-1:0]    len, cnt, out_cnt, win_len;
  logic [READ_LATENCY-1:0] pipe;
  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (bus.req[(int'(rr_ptr) + i) % N_REQ]) win = IW'((int'(rr_ptr) + i) % N_REQ);
    win_len = bus.burst_len[win*LEN_WIDTH +: LEN_WIDTH];
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = |bus.req ? (win_len == '0 ? DONE : ISSUE) : IDLE;
      ISSUE:   state_nx = cnt == len - 1'b1 ? DRAIN : ISSUE;
      DRAIN:   state_nx = cnt == LEN_WIDTH'(READ_LATENCY) ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    bus.busy      = state != IDLE;
    bus.bram_en   = state == ISSUE || state == DRAIN;
    bus.bram_ren  = state == ISSUE;
    bus.grant     = bus.bram_en ? N_REQ'(1) << owner : '0;
    bus.done      = state == DONE ? N_REQ'(1) << owner : '0;
    bus.bram_addr = state == ISSUE ? base + ADDR_WIDTH'(cnt) : '0;
  end
  // cnt restarts on every state change: k-th ISSUE word, then the DRAIN cycle count.
  always_ff @(posedge clk)
    if (rst) begin
      cnt            <= '0;
      owner          <= '0;
      base           <= '0;
      len            <= '0;
      rr_ptr         <= '0;
      pipe           <= '0;
      out_cnt        <= '0;
      bus.data_valid <= 1'b0;
      bus.data_out   <= '0;
      bus.data_idx   <= '0;
    end else begin
      cnt <= state != state_nx ? '0 : cnt + 1'b1;
      if (state == IDLE && |bus.req) begin
        owner <= win;
        base  <= bus.base_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
        len   <= win_len;
      end
      if (state == DONE) rr_ptr <= owner == IW'(N_REQ - 1) ? '0 : owner + 1'b1;
      pipe           <= READ_LATENCY'({pipe, bus.bram_ren});
      bus.data_valid <= pipe[READ_LATENCY-1];
      out_cnt        <= state == IDLE ? '0 : out_cnt + LEN_WIDTH'(pipe[READ_LATENCY-1]);
      if (pipe[READ_LATENCY-1]) begin
        bus.data_out <= bus.bram_dout;
        bus.data_idx <= out_cnt;
      end
    end
endmodule

// File: tb/tb_bram_read_arbiter.sv
// tb_bram_read_arbiter: directed checks of bram_read_arbiter against a 2-cycle-latency BRAM model.
module tb_bram_read_arbiter;
  localparam int N = 4, W = 8, AW = 15, LW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0, errs = 0;
  logic [AW-1:0] a1;
  always #5 clk = ~clk;
  bram_read_arbiter_if #(.N_REQ(N), .W(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();
  bram_read_arbiter #(.N_REQ(N), .W(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .READ_LATENCY(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  function automatic logic [W-1:0] f(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction
  always @(posedge clk) begin
    a1            <= bus.bram_addr;
    bus.bram_dout <= f(a1);
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cfg(input int i, input logic [AW-1:0] b, input logic [LW-1:0] l);
    bus.base_addr[i*AW +: AW] = b;
    bus.burst_len[i*LW +: LW] = l;
  endtask
  task automatic chk_idle_zero(input string tag);
    chk({tag, "_grant"}, 32'(bus.grant), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_valid"}, 32'(bus.data_valid), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_en"}, 32'(bus.bram_en), 0);
    chk({tag, "_ren"}, 32'(bus.bram_ren), 0);
    chk({tag, "_addr"}, 32'(bus.bram_addr), 0);
    chk({tag, "_dout"}, 32'(bus.data_out), 0);
    chk({tag, "_idx"}, 32'(bus.data_idx), 0);
  endtask
  initial begin
    int own, nval;
    logic [AW-1:0] ea;
    bus.req = '0;
    bus.base_addr = '0;
    bus.burst_len = '0;
    // single burst, client 1
    step;
    step;
    chk_idle_zero("reset");
    rst = 1'b0;
    cfg(1, 15'd16400, 8'd8);
    bus.req = 4'b0010;
    for (int c = 1; c <= 12; c++) begin
      step;
      chk("s_grant", 32'(bus.grant), c <= 11 ? 2 : 0);
      chk("s_addr", 32'(bus.bram_addr), c <= 8 ? 16400 + c - 1 : 0);
      chk("s_ren", 32'(bus.bram_ren), c <= 8 ? 1 : 0);
      chk("s_en", 32'(bus.bram_en), c <= 11 ? 1 : 0);
      chk("s_valid", 32'(bus.data_valid), (c >= 4 && c <= 11) ? 1 : 0);
      if (c >= 4 && c <= 11) begin
        ea = AW'(16400 + c - 4);
        chk("s_idx", 32'(bus.data_idx), c - 4);
        chk("s_data", 32'(bus.data_out), 32'(f(ea)));
      end
      chk("s_done", 32'(bus.done), c == 12 ? 2 : 0);
      chk("s_busy", 32'(bus.busy), 1);
    end
    bus.req = '0;
    step;
    chk("s_idle_busy", 32'(bus.busy), 0);
    // round robin, all clients, len 2
    rst = 1'b1;
    step;
    rst = 1'b0;
    for (int i = 0; i < N; i++) cfg(i, AW'(1000 + i * 16), 8'd2);
    bus.req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      own = b % 4;
      for (int c = 1; c <= 6; c++) begin
        step;
        if (c <= 5) chk("rr_grant", 32'(bus.grant), 32'(1 << own));
        if (c <= 2) chk("rr_addr", 32'(bus.bram_addr), 1000 + own * 16 + c - 1);
        chk("rr_done", 32'(bus.done), c == 6 ? 32'(1 << own) : 0);
      end
      if (b == 4) bus.req = '0;
      step;
      chk("rr_gap_busy", 32'(bus.busy), 0);
      chk("rr_gap_grant", 32'(bus.grant), 0);
    end
    // zero length on client 2
    cfg(2, 15'd77, 8'd0);
    bus.req = 4'b0100;
    step;
    chk("z_done", 32'(bus.done), 4);
    chk("z_busy", 32'(bus.busy), 1);
    chk("z_ren", 32'(bus.bram_ren), 0);
    chk("z_valid", 32'(bus.data_valid), 0);
    chk("z_grant", 32'(bus.grant), 0);
    bus.req = '0;
    step;
    chk("z_after_done", 32'(bus.done), 0);
    chk("z_after_busy", 32'(bus.busy), 0);
    chk("z_after_valid", 32'(bus.data_valid), 0);
    // address wrap
    cfg(0, 15'd32766, 8'd4);
    bus.req = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      step;
      if (c <= 4) chk("w_addr", 32'(bus.bram_addr), (32766 + c - 1) % 32768);
      chk("w_valid", 32'(bus.data_valid), (c >= 4 && c <= 7) ? 1 : 0);
      if (c >= 4 && c <= 7) begin
        ea = AW'((32766 + c - 4) % 32768);
        chk("w_idx", 32'(bus.data_idx), c - 4);
        chk("w_data", 32'(bus.data_out), 32'(f(ea)));
      end
      chk("w_done", 32'(bus.done), c == 8 ? 1 : 0);
    end
    bus.req = '0;
    step;
    // reset in the middle of a client 2 burst
    cfg(2, 15'd500, 8'd8);
    bus.req = 4'b0100;
    for (int c = 1; c <= 5; c++) begin
      step;
      chk("m_grant", 32'(bus.grant), 4);
    end
    rst = 1'b1;
    step;
    chk_idle_zero("m_reset");
    rst = 1'b0;
    bus.req = '0;
    for (int c = 0; c < 6; c++) begin
      step;
      chk("m_late_valid", 32'(bus.data_valid), 0);
      chk("m_late_done", 32'(bus.done), 0);
    end
    cfg(0, 15'd200, 8'd1);
    cfg(3, 15'd300, 8'd1);
    bus.req = 4'b1001;
    step;
    chk("m_fresh_grant", 32'(bus.grant), 1);
    chk("m_fresh_addr", 32'(bus.bram_addr), 200);
    for (int c = 2; c <= 5; c++) begin
      step;
      if (c == 4) chk("m_fresh_data", 32'(bus.data_out), 32'(f(15'd200)));
      chk("m_fresh_valid", 32'(bus.data_valid), c == 4 ? 1 : 0);
      chk("m_fresh_done", 32'(bus.done), c == 5 ? 1 : 0);
    end
    bus.req = '0;
    step;
    // request churn: client 0 drops, client 3 arrives mid-burst
    cfg(0, 15'd100, 8'd4);
    cfg(3, 15'd300, 8'd0);
    bus.req = 4'b0001;
    nval = 0;
    for (int c = 1; c <= 8; c++) begin
      step;
      if (c == 2) bus.req = 4'b1000;
      if (c <= 7) chk("c_grant", 32'(bus.grant), 1);
      if (bus.data_valid) nval++;
      chk("c_done", 32'(bus.done), c == 8 ? 1 : 0);
    end
    chk("c_words", 32'(nval), 4);
    step;
    chk("c_gap_busy", 32'(bus.busy), 0);
    chk("c_gap_grant", 32'(bus.grant), 0);
    step;
    chk("c_done3", 32'(bus.done), 8);
    bus.req = '0;
    step;
    chk("c_end_busy", 32'(bus.busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
